// File: rtl/register_file_16x32_pkg.sv
// -----------------------------------------------------------------------------
// register_file_16x32_pkg
// Shared definitions for the architectural register bank and the decoder that
// feeds it. Both sides import this package so the width, register count, the
// PC index and the E-bit-to-register mapping are defined in one place.
//
// Contents
//   WORD_W           default data width
//   NUM_REGS         number of architectural registers (R0..R15)
//   REG_ADDR_W       width of a register address
//   REG_PC           index of the program counter register
//   PC_STEP_DEFAULT  default PC auto-increment
//   pc_op_e          next-state selection for R15
//   e_bit_for_reg()  which write-enable bit selects register n
//   is_multi_hot()   true when more than one write-enable bit is set
// -----------------------------------------------------------------------------
package register_file_16x32_pkg;

    localparam int WORD_W          = 32;
    localparam int NUM_REGS        = 16;
    localparam int REG_ADDR_W      = 4;
    localparam int REG_PC          = 15;
    localparam int PC_STEP_DEFAULT = 4;

    // What R15 does at the next edge (reset is handled separately).
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_LOAD,
        PC_INCR
    } pc_op_e;

    // The decoder is MSB-first: E[15] selects R0 and E[0] selects R15.
    function automatic int e_bit_for_reg(input int n);
        return NUM_REGS - 1 - n;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set; an all-zero vector is not multi-hot.
    function automatic logic is_multi_hot(input logic [NUM_REGS-1:0] e);
        return (e & (e - NUM_REGS'(1))) != '0;
    endfunction

endpackage

// File: rtl/register_file_16x32_if.sv
// -----------------------------------------------------------------------------
// register_file_16x32_if
// Bundles the write, read and status signals of the register bank.
//
// Signals
//   e           one-hot write enables from the decoder (E[15-n] selects Rn)
//   pw          write data
//   sa, sb      read addresses for ports A and B
//   pc_inc      advance R15 by the PC step this cycle
//   pa, pb      contents of R[sa] / R[sb]
//   pc_out      contents of R15
//   onehot_err  high for the cycle after a malformed E was sampled
//
// Modports
//   master  the decoder / writeback / operand-fetch side
//   slave   the register bank
// -----------------------------------------------------------------------------
interface register_file_16x32_if
    import register_file_16x32_pkg::*;
#(
    parameter int WIDTH = WORD_W
) ();

    logic [NUM_REGS-1:0]   e;
    logic [WIDTH-1:0]      pw;
    logic [REG_ADDR_W-1:0] sa;
    logic [REG_ADDR_W-1:0] sb;
    logic                  pc_inc;
    logic [WIDTH-1:0]      pa;
    logic [WIDTH-1:0]      pb;
    logic [WIDTH-1:0]      pc_out;
    logic                  onehot_err;

    modport master (
        output e, pw, sa, sb, pc_inc,
        input  pa, pb, pc_out, onehot_err
    );

    modport slave (
        input  e, pw, sa, sb, pc_inc,
        output pa, pb, pc_out, onehot_err
    );

endinterface

// File: rtl/register_file_16x32_register_ld.sv
// -----------------------------------------------------------------------------
// register_ld
// WIDTH-bit register with synchronous active-high reset to RESET_VAL and a
// load enable. Used for the general-purpose registers R0..R14.
//
// Ports
//   i_clk    clock, rising edge
//   i_reset  synchronous reset, active high, overrides i_load
//   i_load   capture i_d at the next edge
//   i_d      data in
//   o_q      registered value
// -----------------------------------------------------------------------------
module register_ld #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: state is updated with <= so every register samples its inputs as
    // they were before the edge, regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file_16x32.sv
// -----------------------------------------------------------------------------
// register_file_16x32
// Architectural register bank R0..R15 driven directly by the one-hot write
// enables of the 4-to-16 decoder. R15 is the PC: a legal write to it wins,
// otherwise it advances by PC_STEP when pc_inc is high. A write-enable vector
// with two or more bits set is rejected as a whole (no register write, no PC
// advance) and flagged on onehot_err for the following cycle.
//
// Ports
//   i_clk    clock, rising edge
//   i_reset  synchronous reset, active high; clears R0..R14, loads R15 with
//            PC_RESET, clears onehot_err, and overrides any write/increment
//   bus      register_file_16x32_if.slave
//              in : e, pw, sa, sb, pc_inc
//              out: pa, pb (combinational read muxes, no write bypass),
//                   pc_out (R15), onehot_err (registered)
// -----------------------------------------------------------------------------
module register_file_16x32
    import register_file_16x32_pkg::*;
#(
    parameter int              WIDTH    = WORD_W,
    parameter int              PC_STEP  = PC_STEP_DEFAULT,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    register_file_16x32_if.slave   bus
);

    logic             w_multi_hot;
    logic [WIDTH-1:0] w_regs [NUM_REGS];
    logic [WIDTH-1:0] r_pc;
    logic             r_onehot_err;
    pc_op_e           w_pc_op;

    // E = 0 is a legal no-op; only two or more set bits are an error.
    assign w_multi_hot = is_multi_hot(bus.e);

    // -------------------------------------------------------------------------
    // R0..R14: plain load-enabled registers. A malformed E blocks every load,
    // so a legal E can enable at most one of them.
    // -------------------------------------------------------------------------
    for (genvar n = 0; n < NUM_REGS - 1; n++) begin : g_gpr
        localparam int EBIT = e_bit_for_reg(n);

        register_ld #(
            .WIDTH     (WIDTH),
            .RESET_VAL ('0)
        ) u_reg (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (bus.e[EBIT] & ~w_multi_hot),
            .i_d     (bus.pw),
            .o_q     (w_regs[n])
        );
    end

    // -------------------------------------------------------------------------
    // R15 / PC: load beats increment; a malformed E freezes it.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pc_op = PC_HOLD;
        if (!w_multi_hot) begin
            if (bus.e[e_bit_for_reg(REG_PC)]) begin
                w_pc_op = PC_LOAD;
            end else if (bus.pc_inc) begin
                w_pc_op = PC_INCR;
            end
        end
    end

    // The increment wraps modulo 2^WIDTH by truncation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= PC_RESET;
        end else begin
            case (w_pc_op)
                PC_LOAD: r_pc <= bus.pw;
                PC_INCR: r_pc <= r_pc + WIDTH'(PC_STEP);
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign w_regs[REG_PC] = r_pc;

    // -------------------------------------------------------------------------
    // Error flag: one cycle of onehot_err per malformed E, cleared by any edge
    // with a legal E (including all-zero).
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_onehot_err <= 1'b0;
        end else begin
            r_onehot_err <= w_multi_hot;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: pure muxes of current state. A register written this cycle
    // still reads its old value until the edge.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.pa = w_regs[bus.sa];
        bus.pb = w_regs[bus.sb];
    end

    assign bus.pc_out     = r_pc;
    assign bus.onehot_err = r_onehot_err;

endmodule
